aes_key_sched: RTL and testbench
================================

AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have parameter WPC, default 4, meaning key words generated per clock; legal values 1, 2, 4.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning read-port latency in cycles; legal values 0, 1.
REQ-003 SHALL have port eph1, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins an expansion.
REQ-006 SHALL have port key_size, input, 2 bits: 00 = 128-bit key, 01 = 192-bit key, 1x = 256-bit key; sampled only when start = 1.
REQ-007 SHALL have port true_key, input, 256 bits: cipher key, MSB-aligned (128-bit key in [255:128], 192-bit key in [255:64]); sampled only when start = 1.
REQ-008 SHALL have port busy, output, 1 bit: expansion in progress.
REQ-009 SHALL have port key_done, output, 1 bit: level signal meaning all round keys are valid.
REQ-010 SHALL have port rd_en, input, 1 bit: round-key read request.
REQ-011 SHALL have port rd_round, input, 4 bits: round index to read, 0..Nr.
REQ-012 SHALL have port rd_key, output, 128 bits: round key, formed as {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-013 SHALL have port rd_valid, output, 1 bit: qualifies rd_key.

Function
REQ-014 SHALL derive Nk / Nr per key size: 4 / 10, 6 / 12, 8 / 14; total words Nw = 4(Nr+1), i.e. 44, 52, 60.
REQ-015 SHALL implement the FSM states IDLE, LOAD, EXPAND, DONE.
REQ-016 SHALL take these FSM transitions:
- any state, start = 1 -> LOAD;
- LOAD -> EXPAND;
- EXPAND -> DONE when the last word is written;
- DONE holds until start.
REQ-017 In LOAD, SHALL latch key_size and write w[0..Nk-1] from true_key, with w[0] = the top 32 bits.
REQ-018 In EXPAND, SHALL write words i .. i+WPC-1 per cycle, where w[i] = w[i-Nk] ^ t. The lane term t is:
- SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0} when i mod Nk = 0;
- SubWord(w[i-1]) when Nk = 8 and i mod 8 = 4;
- w[i-1] otherwise.
Lanes chain within a cycle.
REQ-019 SHALL step Rcon through 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, advancing once per i mod Nk = 0 event, in lane order.
REQ-020 SHALL suppress words with index >= Nw in the final group (e.g. 192-bit key with WPC = 4: only 2 words are written in the last cycle).
REQ-021 SHALL keep the EXPAND length at ceil((Nw-Nk)/WPC) cycles; for WPC = 4 this is 10, 12, 13.
REQ-022 SHALL raise key_done on the first DONE cycle and hold it until the next start or reset.
REQ-023 SHALL drive busy = 1 in LOAD and EXPAND only.
REQ-024 SHALL treat start during LOAD, EXPAND or DONE as an abort-and-restart: key_done drops the next cycle, the word counter and Rcon reinitialise, and new inputs are sampled.
REQ-025 SHALL return a read on rd_en after RD_LAT cycles with rd_valid = 1 and rd_key = round rd_round, if key_done = 1 and rd_round <= Nr at request time.
REQ-026 SHALL return rd_valid = 0 and rd_key = 0 for a read with key_done = 0 or rd_round > Nr.
REQ-027 SHALL return the new key's data for a read coincident with start only after the new key_done.

Reset
REQ-028 On reset SHALL force: FSM to IDLE, busy = 0, key_done = 0, rd_valid = 0, rd_key = 0, word counter = 0, Rcon = 01.
REQ-029 Word storage SHALL NOT require reset, because reads are gated by key_done.
REQ-030 Reset asserted mid-EXPAND SHALL abort; no key_done results until a new start after deassertion.

Structure
REQ-031 Shared package aes_pkg SHALL hold:
- the SBOX constant;
- the key_size enum;
- the Rcon table;
- the Nk/Nr/Nw lookup function.
REQ-032 SHALL contain sub-module aes_subword (4 parallel SBOX lookups on a 32-bit word), instantiated once per lane (WPC instances).
REQ-033 Word storage SHALL be a 60 x 32 register array; rd_key SHALL be registered when RD_LAT = 1.

Verification
REQ-034 SHALL cover: 128-bit key 2b7e151628aed2a6abf7158809cf4f3c -> round 1 = a0fafe1788542cb123a339392a6c7605 and round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; key_done 12 cycles after start (WPC = 4).
REQ-035 SHALL cover: 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> round 12 = e98ba06f448c773c8ecc720401002202; EXPAND = 12 cycles.
REQ-036 SHALL cover: 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round 14 = fe4890d1e6188d0b046df344706c631e; repeat with WPC = 1 and 2, same keys.
REQ-037 SHALL cover: start of the 128-bit key, then start of the 256-bit key at EXPAND cycle 5 -> round 14 as in REQ-036; key_done never pulses for the aborted run.
REQ-038 SHALL cover: after a 128-bit done, rd_round = 11 -> rd_valid = 0, rd_key = 0; rd_en before key_done -> rd_valid = 0.
REQ-039 SHALL cover: reset asserted mid-EXPAND -> busy and key_done = 0 immediately; a following start yields correct keys.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-size encoding and key geometry lookup
package aes_pkg;

    typedef enum logic [1:0] {
        KS_128 = 2'b00,
        KS_192 = 2'b01,
        KS_256 = 2'b10
    } key_size_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOAD   = 2'b01,
        S_EXPAND = 2'b10,
        S_DONE   = 2'b11
    } sched_state_e;

    typedef struct packed {
        logic [3:0] nk;
        logic [3:0] nr;
        logic [5:0] nw;
    } key_geom_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Index 10 is reached only after the final Rcon event, so it never feeds a written word.
    function automatic logic [7:0] rcon_of(logic [3:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

    function automatic key_size_e decode_ks(logic [1:0] ks);
        return ks[1] ? KS_256 : (ks[0] ? KS_192 : KS_128);
    endfunction

    function automatic key_geom_t key_geom(key_size_e ks);
        case (ks)
            KS_192:  return '{nk: 4'd6, nr: 4'd12, nw: 6'd52};
            KS_256:  return '{nk: 4'd8, nr: 4'd14, nw: 6'd60};
            default: return '{nk: 4'd4, nr: 4'd10, nw: 6'd44};
        endcase
    endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// rtl/aes_key_sched_if.sv - control and round-key read bundle of the key scheduler
interface aes_key_sched_if;
    logic         start;
    logic [1:0]   key_size;
    logic [255:0] true_key;
    logic         busy;
    logic         key_done;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;

    modport master (
        output start, key_size, true_key, rd_en, rd_round,
        input  busy, key_done, rd_key, rd_valid
    );

    modport slave (
        input  start, key_size, true_key, rd_en, rd_round,
        output busy, key_done, rd_key, rd_valid
    );
endinterface

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - four parallel S-box lookups on a 32-bit word
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
    end
endmodule

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - AES-128/192/256 key expansion, WPC words per clock, round-key read port
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int WPC    = 4,
    parameter int RD_LAT = 1
) (
    input  logic          eph1,
    input  logic          reset,
    aes_key_sched_if.slave bus
);
    sched_state_e  state_q, state_d;
    key_size_e     ks_q;
    logic [255:0]  key_q;
    logic [5:0]    cnt_q;
    logic [2:0]    mod_q;
    logic [3:0]    rcon_q;
    logic [31:0]   w_q [60];
    key_geom_t     geom;
    logic [32*WPC-1:0] new_flat;
    logic [WPC-1:0]    act_flat;
    logic          last_grp;

    assign geom     = key_geom(ks_q);
    assign last_grp = (cnt_q + 6'(WPC)) >= geom.nw;

    // Lane g produces w[cnt_q+g]; its w[i-1] is the previous lane's result, so lanes chain combinationally.
    for (genvar g = 0; g < WPC; g++) begin : g_lane
        logic [5:0]  idx;
        logic [2:0]  mod_in, mod_out;
        logic [3:0]  rc_in, rc_out;
        logic [31:0] prev_w, old_w, sub_in, sub_out, t_w, new_w;
        logic        act, rot_ev, sub_ev;

        if (g == 0) begin : g_head
            assign prev_w = w_q[cnt_q - 6'd1];
            assign mod_in = mod_q;
            assign rc_in  = rcon_q;
        end else begin : g_chain
            assign prev_w = g_lane[g-1].new_w;
            assign mod_in = g_lane[g-1].mod_out;
            assign rc_in  = g_lane[g-1].rc_out;
        end

        assign idx     = cnt_q + 6'(g);
        assign act     = idx < geom.nw;
        assign rot_ev  = (mod_in == 3'd0);
        assign sub_ev  = (geom.nk == 4'd8) && (mod_in == 3'd4);
        assign sub_in  = rot_ev ? {prev_w[23:0], prev_w[31:24]} : prev_w;

        aes_subword u_subword (
            .word_i (sub_in),
            .word_o (sub_out)
        );

        assign t_w     = rot_ev ? (sub_out ^ {rcon_of(rc_in), 24'h0}) : (sub_ev ? sub_out : prev_w);
        assign old_w   = w_q[idx - {2'b00, geom.nk}];
        assign new_w   = old_w ^ t_w;
        assign mod_out = ({1'b0, mod_in} == (geom.nk - 4'd1)) ? 3'd0 : (mod_in + 3'd1);
        assign rc_out  = rc_in + 4'(rot_ev && act);

        assign new_flat[32*g +: 32] = new_w;
        assign act_flat[g]          = act;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   state_d = S_EXPAND;
            S_EXPAND: if (last_grp) state_d = S_DONE;
            default:  state_d = state_q;
        endcase
        if (bus.start) state_d = S_LOAD;
    end

    assign bus.busy     = (state_q == S_LOAD) || (state_q == S_EXPAND);
    assign bus.key_done = (state_q == S_DONE);

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ks_q    <= KS_128;
            key_q   <= '0;
            cnt_q   <= '0;
            mod_q   <= '0;
            rcon_q  <= '0;
        end else begin
            state_q <= state_d;
            if (bus.start) begin
                ks_q   <= decode_ks(bus.key_size);
                key_q  <= bus.true_key;
                cnt_q  <= '0;
                mod_q  <= '0;
                rcon_q <= '0;
            end else if (state_q == S_LOAD) begin
                cnt_q  <= {2'b00, geom.nk};
                mod_q  <= '0;
                rcon_q <= '0;
            end else if (state_q == S_EXPAND) begin
                cnt_q  <= cnt_q + 6'(WPC);
                mod_q  <= g_lane[WPC-1].mod_out;
                rcon_q <= g_lane[WPC-1].rc_out;
            end
        end
    end

    // Storage is unreset: nothing reads it unless key_done, which needs a full fresh expansion.
    always_ff @(posedge eph1) begin
        if (state_q == S_LOAD) begin
            for (int k = 0; k < 8; k++) w_q[k] <= key_q[32*(7-k) +: 32];
        end else if (state_q == S_EXPAND) begin
            for (int g = 0; g < WPC; g++) begin
                if (act_flat[g]) w_q[cnt_q + 6'(g)] <= new_flat[32*g +: 32];
            end
        end
    end

    logic [5:0]   rd_base;
    logic         rd_valid_d;
    logic [127:0] rd_key_d;

    assign rd_base    = {bus.rd_round, 2'b00};
    assign rd_valid_d = bus.rd_en && (state_q == S_DONE) && (bus.rd_round <= geom.nr);
    assign rd_key_d   = rd_valid_d ? {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]}
                                   : 128'h0;

    if (RD_LAT == 1) begin : g_rd_reg
        logic         rd_valid_q;
        logic [127:0] rd_key_q;
        always_ff @(posedge eph1 or posedge reset) begin
            if (reset) begin
                rd_valid_q <= 1'b0;
                rd_key_q   <= '0;
            end else begin
                rd_valid_q <= rd_valid_d;
                rd_key_q   <= rd_key_d;
            end
        end
        assign bus.rd_valid = rd_valid_q;
        assign bus.rd_key   = rd_key_q;
    end else begin : g_rd_comb
        assign bus.rd_valid = rd_valid_d;
        assign bus.rd_key   = rd_key_d;
    end
endmodule

// File: tb/tb_aes_key_sched.sv
// tb/tb_aes_key_sched.sv - self-checking bench for aes_key_sched at WPC 4/2/1
module tb_aes_key_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_size;
    logic [255:0] true_key;
    logic         rd_en;
    logic [3:0]   rd_round;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  sbox_ref [256];
    logic [31:0] ref_w [60];
    int          ref_nk, ref_nr, ref_nw;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes_key_sched_if if4 ();
    aes_key_sched_if if2 ();
    aes_key_sched_if if1 ();

    assign if4.start = start;  assign if4.key_size = key_size;  assign if4.true_key = true_key;
    assign if4.rd_en = rd_en;  assign if4.rd_round = rd_round;
    assign if2.start = start;  assign if2.key_size = key_size;  assign if2.true_key = true_key;
    assign if2.rd_en = rd_en;  assign if2.rd_round = rd_round;
    assign if1.start = start;  assign if1.key_size = key_size;  assign if1.true_key = true_key;
    assign if1.rd_en = rd_en;  assign if1.rd_round = rd_round;

    aes_key_sched #(.WPC(4), .RD_LAT(1)) u_dut4 (.eph1(clk), .reset(rst), .bus(if4));
    aes_key_sched #(.WPC(2), .RD_LAT(0)) u_dut2 (.eph1(clk), .reset(rst), .bus(if2));
    aes_key_sched #(.WPC(1), .RD_LAT(1)) u_dut1 (.eph1(clk), .reset(rst), .bus(if1));

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, r, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv; r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_ref[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(logic [31:0] x);
        return {sbox_ref[x[31:24]], sbox_ref[x[23:16]], sbox_ref[x[15:8]], sbox_ref[x[7:0]]};
    endfunction

    task automatic model(input logic [1:0] ks, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        ref_nk = (ks == 2'b00) ? 4 : ((ks == 2'b01) ? 6 : 8);
        ref_nr = ref_nk + 6;
        ref_nw = 4 * (ref_nr + 1);
        rc = 8'h01;
        for (int i = 0; i < ref_nk; i++) ref_w[i] = key[255 - 32*i -: 32];
        for (int i = ref_nk; i < ref_nw; i++) begin
            t = ref_w[i-1];
            if (i % ref_nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (ref_nk == 8 && i % 8 == 4) begin
                t = sub_word(t);
            end
            ref_w[i] = ref_w[i - ref_nk] ^ t;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input int r, input logic ok);
        logic [127:0] e;
        e = '0;
        if (ok) e = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
        rd_en = 1'b1;
        rd_round = 4'(r);
        #1;
        chk($sformatf("rd2_valid_r%0d", r), 128'(if2.rd_valid), 128'(ok));
        chk($sformatf("rd2_key_r%0d", r), if2.rd_key, e);
        step();
        chk($sformatf("rd4_valid_r%0d", r), 128'(if4.rd_valid), 128'(ok));
        chk($sformatf("rd4_key_r%0d", r), if4.rd_key, e);
        chk($sformatf("rd1_valid_r%0d", r), 128'(if1.rd_valid), 128'(ok));
        chk($sformatf("rd1_key_r%0d", r), if1.rd_key, e);
        rd_en = 1'b0;
    endtask

    task automatic kat(input string tag, input int r, input logic [127:0] exp);
        rd_en = 1'b1;
        rd_round = 4'(r);
        step();
        chk(tag, if4.rd_key, exp);
        rd_en = 1'b0;
    endtask

    task automatic run_key(input string tag, input logic [1:0] ks, input logic [255:0] key);
        int n, t4, t2, t1, span;
        model(ks, key);
        start = 1'b1; key_size = ks; true_key = key;
        step();
        start = 1'b0;
        chk({tag, "_load_done"}, 128'(if4.key_done), 128'(0));
        chk({tag, "_load_busy"}, 128'(if4.busy), 128'(1));
        n = 1; t4 = 0; t2 = 0; t1 = 0;
        while ((t4 == 0 || t2 == 0 || t1 == 0) && n < 200) begin
            step();
            n++;
            if (t4 == 0 && if4.key_done) t4 = n;
            if (t2 == 0 && if2.key_done) t2 = n;
            if (t1 == 0 && if1.key_done) t1 = n;
        end
        span = ref_nw - ref_nk;
        chk({tag, "_lat4"}, 128'(t4), 128'(2 + (span + 3) / 4));
        chk({tag, "_lat2"}, 128'(t2), 128'(2 + (span + 1) / 2));
        chk({tag, "_lat1"}, 128'(t1), 128'(2 + span));
        chk({tag, "_busy_done"}, 128'(if4.busy), 128'(0));
        for (int r = 0; r <= ref_nr; r++) read_chk(r, 1'b1);
    endtask

    initial begin
        int pulses;
        build_sbox();
        rst = 1'b1; start = 1'b0; key_size = 2'b00; true_key = '0; rd_en = 1'b0; rd_round = 4'd0;
        step();
        step();
        chk("rst_busy", 128'(if4.busy), 128'(0));
        chk("rst_key_done", 128'(if4.key_done), 128'(0));
        chk("rst_rd_valid", 128'(if4.rd_valid), 128'(0));
        chk("rst_rd_key", if4.rd_key, 128'h0);
        chk("rst_key_done1", 128'(if1.key_done), 128'(0));
        rst = 1'b0;
        step();

        read_chk(0, 1'b0);

        run_key("k128", 2'b00, K128);
        kat("kat128_r1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        kat("kat128_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_chk(11, 1'b0);
        read_chk(15, 1'b0);

        run_key("k192", 2'b01, K192);
        kat("kat192_r12", 12, 128'he98ba06f448c773c8ecc720401002202);
        read_chk(13, 1'b0);

        run_key("k256", 2'b10, K256);
        kat("kat256_r14", 14, 128'hfe4890d1e6188d0b046df344706c631e);

        for (int k = 0; k < 4; k++) begin
            run_key($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        end

        start = 1'b1; key_size = 2'b00; true_key = K128;
        step();
        start = 1'b0;
        pulses = 0;
        if (if4.key_done || if2.key_done || if1.key_done) pulses++;
        for (int c = 0; c < 5; c++) begin
            step();
            if (if4.key_done || if2.key_done || if1.key_done) pulses++;
        end
        chk("abort_busy", 128'(if4.busy), 128'(1));
        chk("abort_no_done", 128'(pulses), 128'(0));
        run_key("abort256", 2'b10, K256);
        kat("abort_kat_r14", 14, 128'hfe4890d1e6188d0b046df344706c631e);

        start = 1'b1; key_size = 2'b10; true_key = K192;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b1;
        #1;
        chk("midrst_busy4", 128'(if4.busy), 128'(0));
        chk("midrst_done4", 128'(if4.key_done), 128'(0));
        chk("midrst_busy1", 128'(if1.busy), 128'(0));
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk("postrst_done4", 128'(if4.key_done), 128'(0));
        chk("postrst_done2", 128'(if2.key_done), 128'(0));
        read_chk(0, 1'b0);
        run_key("postrst", 2'b01,
                {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
